// File: rtl/pattern_tx_if.sv
// Handshake and serial-stream bundle between a controller and pattern_tx.
interface pattern_tx_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             data;
  logic             valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_n, gap,
    input  data, valid, frame_start, busy, done
  );

  modport slave (
    input  start, pattern, repeat_n, gap,
    output data, valid, frame_start, busy, done
  );
endinterface

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB
// first, repeat_n times, with an optional idle gap between frames.
// All outputs are registered; start is only honoured in IDLE.
module pattern_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  pattern_tx_if.slave bus
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] pat_q;   // pattern held for reloads between frames
  logic [WIDTH-1:0] sreg;    // bits still to be sent in this frame, MSB next
  logic [BW-1:0]    bcnt;    // index of the bit currently on `data`
  logic [CNT_W-1:0] rem;     // frames remaining, including the one in flight
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gcnt;    // gap cycles left, including the current one

  // Transfer FSM with registered stream/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      pat_q           <= '0;
      sreg            <= '0;
      bcnt            <= '0;
      rem             <= '0;
      gap_q           <= '0;
      gcnt            <= '0;
      bus.data        <= 1'b0;
      bus.valid       <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            pat_q <= bus.pattern;
            gap_q <= bus.gap;
            rem   <= bus.repeat_n;
            if (bus.repeat_n == '0) begin
              // Nothing to send: report completion without ever going busy.
              state    <= S_DONE;
              bus.done <= 1'b1;
            end else begin
              state           <= S_SHIFT;
              sreg            <= bus.pattern << 1;
              bcnt            <= '0;
              bus.data        <= bus.pattern[WIDTH-1];
              bus.valid       <= 1'b1;
              bus.frame_start <= 1'b1;
              bus.busy        <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (bcnt != LAST_BIT) begin
            bus.data        <= sreg[WIDTH-1];
            sreg            <= sreg << 1;
            bcnt            <= bcnt + 1'b1;
            bus.frame_start <= 1'b0;
          end else begin
            // LSB is on the wire now; decide what follows this frame.
            rem <= rem - CNT_W'(1);
            if (rem == CNT_W'(1)) begin
              state           <= S_DONE;
              bus.data        <= 1'b0;
              bus.valid       <= 1'b0;
              bus.frame_start <= 1'b0;
              bus.busy        <= 1'b0;
              bus.done        <= 1'b1;
            end else if (gap_q == '0) begin
              // Back-to-back: next MSB immediately, no valid bubble.
              sreg            <= pat_q << 1;
              bcnt            <= '0;
              bus.data        <= pat_q[WIDTH-1];
              bus.frame_start <= 1'b1;
            end else begin
              state           <= S_GAP;
              gcnt            <= gap_q;
              bus.data        <= 1'b0;
              bus.valid       <= 1'b0;
              bus.frame_start <= 1'b0;
            end
          end
        end

        S_GAP: begin
          if (gcnt == GAP_W'(1)) begin
            state           <= S_SHIFT;
            sreg            <= pat_q << 1;
            bcnt            <= '0;
            bus.data        <= pat_q[WIDTH-1];
            bus.valid       <= 1'b1;
            bus.frame_start <= 1'b1;
          end else begin
            gcnt <= gcnt - GAP_W'(1);
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          bus.done <= 1'b0;
        end

        default: begin
          state           <= S_IDLE;
          bus.data        <= 1'b0;
          bus.valid       <= 1'b0;
          bus.frame_start <= 1'b0;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: a 4-bit and an 8-bit instance share clk/rst.
module tb_pattern_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_tx_if #(.WIDTH(4), .CNT_W(8), .GAP_W(4)) if4 ();
  pattern_tx_if #(.WIDTH(8), .CNT_W(8), .GAP_W(4)) if8 ();

  pattern_tx #(.WIDTH(4), .CNT_W(8), .GAP_W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  pattern_tx #(.WIDTH(8), .CNT_W(8), .GAP_W(4)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  int tests = 0;
  int fails = 0;

  // Captured per-cycle outputs, cycle 1 ends up as bit n-1.
  logic [31:0] cd, cv, cf, cb, cdn;

  task automatic start_xfer(input bit w8, input logic [7:0] pat,
                            input logic [7:0] rep, input logic [3:0] gp,
                            input bit hold);
    @(negedge clk);
    if (w8) begin
      if8.pattern = pat; if8.repeat_n = rep; if8.gap = gp; if8.start = 1'b1;
    end else begin
      if4.pattern = pat[3:0]; if4.repeat_n = rep; if4.gap = gp; if4.start = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      if4.start = 1'b0;
      if8.start = 1'b0;
    end
  endtask

  task automatic capture(input bit w8, input int n);
    cd = '0; cv = '0; cf = '0; cb = '0; cdn = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (w8) begin
        cd = {cd[30:0], if8.data};  cv = {cv[30:0], if8.valid};
        cf = {cf[30:0], if8.frame_start}; cb = {cb[30:0], if8.busy};
        cdn = {cdn[30:0], if8.done};
      end else begin
        cd = {cd[30:0], if4.data};  cv = {cv[30:0], if4.valid};
        cf = {cf[30:0], if4.frame_start}; cb = {cb[30:0], if4.busy};
        cdn = {cdn[30:0], if4.done};
      end
    end
  endtask

  // Count 1101 occurrences (overlapping) in the valid bits of the last capture.
  function automatic int count_1101(input int n);
    logic [3:0] sh = '0;
    int cnt = 0;
    int seen = 0;
    for (int k = n - 1; k >= 0; k--) begin
      if (cv[k]) begin
        sh = {sh[2:0], cd[k]};
        seen++;
        if (seen >= 4 && sh == 4'b1101) cnt++;
      end
    end
    return cnt;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({if4.data, if4.valid, if4.frame_start, if4.busy, if4.done} !== 5'b0) begin
      fails++; $display("FAIL reset_w4 got %b exp 00000",
        {if4.data, if4.valid, if4.frame_start, if4.busy, if4.done});
    end
    tests++;
    if ({if8.data, if8.valid, if8.frame_start, if8.busy, if8.done} !== 5'b0) begin
      fails++; $display("FAIL reset_w8 got %b exp 00000",
        {if8.data, if8.valid, if8.frame_start, if8.busy, if8.done});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    start_xfer(1'b0, 8'b1101, 8'd1, 4'd0, 1'b0);
    capture(1'b0, 6);
    tests++; if (cd !== 32'b110100) begin fails++; $display("FAIL single_data got %b exp 110100", cd[5:0]); end
    tests++; if (cv !== 32'b111100) begin fails++; $display("FAIL single_valid got %b exp 111100", cv[5:0]); end
    tests++; if (cf !== 32'b100000) begin fails++; $display("FAIL single_fs got %b exp 100000", cf[5:0]); end
    tests++; if (cb !== 32'b111100) begin fails++; $display("FAIL single_busy got %b exp 111100", cb[5:0]); end
    tests++; if (cdn !== 32'b000010) begin fails++; $display("FAIL single_done got %b exp 000010", cdn[5:0]); end
    tests++; if (count_1101(6) !== 1) begin fails++; $display("FAIL single_detect got %0d exp 1", count_1101(6)); end
  endtask

  task automatic test_back_to_back();
    start_xfer(1'b0, 8'b1101, 8'd3, 4'd0, 1'b0);
    capture(1'b0, 14);
    tests++; if (cd !== 32'b11011101110100) begin fails++; $display("FAIL b2b_data got %b exp 11011101110100", cd[13:0]); end
    tests++; if (cv !== 32'b11111111111100) begin fails++; $display("FAIL b2b_valid got %b exp 11111111111100", cv[13:0]); end
    tests++; if (cf !== 32'b10001000100000) begin fails++; $display("FAIL b2b_fs got %b exp 10001000100000", cf[13:0]); end
    tests++; if (cb !== 32'b11111111111100) begin fails++; $display("FAIL b2b_busy got %b exp 11111111111100", cb[13:0]); end
    tests++; if (cdn !== 32'b00000000000010) begin fails++; $display("FAIL b2b_done got %b exp 00000000000010", cdn[13:0]); end
    tests++; if (count_1101(14) !== 3) begin fails++; $display("FAIL b2b_detect got %0d exp 3", count_1101(14)); end
  endtask

  task automatic test_gap();
    start_xfer(1'b0, 8'b1011, 8'd2, 4'd2, 1'b0);
    capture(1'b0, 12);
    tests++; if (cd !== 32'b101100101100) begin fails++; $display("FAIL gap_data got %b exp 101100101100", cd[11:0]); end
    tests++; if (cv !== 32'b111100111100) begin fails++; $display("FAIL gap_valid got %b exp 111100111100", cv[11:0]); end
    tests++; if (cf !== 32'b100000100000) begin fails++; $display("FAIL gap_fs got %b exp 100000100000", cf[11:0]); end
    tests++; if (cb !== 32'b111111111100) begin fails++; $display("FAIL gap_busy got %b exp 111111111100", cb[11:0]); end
    tests++; if (cdn !== 32'b000000000010) begin fails++; $display("FAIL gap_done got %b exp 000000000010", cdn[11:0]); end
  endtask

  task automatic test_zero_and_ignored_start();
    start_xfer(1'b0, 8'b1111, 8'd0, 4'd0, 1'b0);
    capture(1'b0, 3);
    tests++; if (cdn !== 32'b100) begin fails++; $display("FAIL zero_done got %b exp 100", cdn[2:0]); end
    tests++; if (cv !== 32'b0) begin fails++; $display("FAIL zero_valid got %b exp 000", cv[2:0]); end
    tests++; if (cb !== 32'b0) begin fails++; $display("FAIL zero_busy got %b exp 000", cb[2:0]); end
    // start stays high; inputs change right after acceptance
    start_xfer(1'b0, 8'b1101, 8'd2, 4'd0, 1'b1);
    if4.pattern = 4'b0000; if4.repeat_n = 8'd5; if4.gap = 4'd3;
    capture(1'b0, 10);
    if4.start = 1'b0;
    tests++; if (cd !== 32'b1101110100) begin fails++; $display("FAIL held_data got %b exp 1101110100", cd[9:0]); end
    tests++; if (cv !== 32'b1111111100) begin fails++; $display("FAIL held_valid got %b exp 1111111100", cv[9:0]); end
    tests++; if (cdn !== 32'b0000000010) begin fails++; $display("FAIL held_done got %b exp 0000000010", cdn[9:0]); end
    capture(1'b0, 4);
    tests++; if (cv !== 32'b0) begin fails++; $display("FAIL held_after got %b exp 0000", cv[3:0]); end
  endtask

  task automatic test_reset_mid();
    start_xfer(1'b0, 8'b1101, 8'd3, 4'd0, 1'b0);
    capture(1'b0, 3);
    tests++; if (cd !== 32'b110) begin fails++; $display("FAIL mid_pre_data got %b exp 110", cd[2:0]); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({if4.data, if4.valid, if4.frame_start, if4.busy, if4.done} !== 5'b0) begin
      fails++; $display("FAIL mid_rst_outputs got %b exp 00000",
        {if4.data, if4.valid, if4.frame_start, if4.busy, if4.done});
    end
    @(negedge clk);
    rst = 1'b0;
    capture(1'b0, 14);
    tests++; if (cdn !== 32'b0) begin fails++; $display("FAIL mid_no_done got %b exp 0", cdn[13:0]); end
    tests++; if (cv !== 32'b0) begin fails++; $display("FAIL mid_no_valid got %b exp 0", cv[13:0]); end
    start_xfer(1'b0, 8'b1101, 8'd1, 4'd0, 1'b0);
    capture(1'b0, 6);
    tests++; if (cd !== 32'b110100) begin fails++; $display("FAIL mid_restart_data got %b exp 110100", cd[5:0]); end
    tests++; if (cdn !== 32'b000010) begin fails++; $display("FAIL mid_restart_done got %b exp 000010", cdn[5:0]); end
  endtask

  task automatic test_width8();
    start_xfer(1'b1, 8'hA5, 8'd2, 4'd1, 1'b0);
    capture(1'b1, 20);
    tests++; if (cd !== 32'b10100101010100101000) begin fails++; $display("FAIL w8_data got %b exp 10100101010100101000", cd[19:0]); end
    tests++; if (cv !== 32'b11111111011111111000) begin fails++; $display("FAIL w8_valid got %b exp 11111111011111111000", cv[19:0]); end
    tests++; if (cf !== 32'b10000000010000000000) begin fails++; $display("FAIL w8_fs got %b exp 10000000010000000000", cf[19:0]); end
    tests++; if (cb !== 32'b11111111111111111000) begin fails++; $display("FAIL w8_busy got %b exp 11111111111111111000", cb[19:0]); end
    tests++; if (cdn !== 32'b00000000000000000100) begin fails++; $display("FAIL w8_done got %b exp 00000000000000000100", cdn[19:0]); end
  endtask

  initial begin
    if4.start = 1'b0; if4.pattern = '0; if4.repeat_n = '0; if4.gap = '0;
    if8.start = 1'b0; if8.pattern = '0; if8.repeat_n = '0; if8.gap = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_zero_and_ignored_start();
    test_reset_mid();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
Serial pattern transmitter that drives the single-bit `data` stream consumed by the team's sequence detectors (e.g. the 1101 detector). It loads a WIDTH-bit pattern and shifts it out MSB first, one bit per clock. The pattern is sent a programmable number of times, with an optional idle gap between repetitions. Used as the stimulus source on the board and in detector benches, with a start/busy/done handshake to the controlling logic.

Parameters:
WIDTH, 4, pattern length in bits (>=2)
CNT_W, 8, width of repeat-count input
GAP_W, 4, width of inter-frame gap input

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
pattern  input  WIDTH  pattern to send, latched on accepted start
repeat_n  input  CNT_W  number of frames to send, latched on accepted start
gap  input  GAP_W  idle cycles between frames, latched on accepted start
data  output  1  serial bit, MSB of the current frame first
valid  output  1  high when `data` carries a pattern bit
frame_start  output  1  one-cycle pulse coincident with bit 0 (MSB) of each frame
busy  output  1  high from accepted start until the cycle before `done`
done  output  1  one-cycle pulse when the transfer completes

Behaviour:
- Clock and reset: one clock `clk`; synchronous active-high reset `rst`, named as elsewhere in the codebase.
- Reset: `rst` is sampled at posedge and has priority over everything else.
  - FSM goes to IDLE.
  - `data`, `valid`, `frame_start`, `busy` and `done` are all 0.
  - Internal shift register and counters are cleared.
  - Reset mid-transfer aborts the transfer immediately, with no `done` pulse.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - Outputs 0.
  - On posedge with start=1:
    - Latch `pattern`, `repeat_n` and `gap`.
    - If repeat_n=0: go to DONE, so `done` is high the next cycle, `busy` stays 0 and no bits are sent.
    - Otherwise: go to SHIFT. After this edge, data=pattern[WIDTH-1], valid=1, frame_start=1, busy=1.
- SHIFT:
  - One bit per cycle, MSB first. valid=1 for exactly WIDTH consecutive cycles per frame.
  - frame_start is high only on the first bit of each frame.
  - After the last bit (LSB), the remaining count decrements.
    - Remaining >0 and gap=0: reload the latched pattern and continue SHIFT back-to-back, with no valid-low bubble.
    - Remaining >0 and gap>0: go to GAP.
    - Remaining =0: go to DONE.
- GAP:
  - data=0, valid=0, busy=1 for exactly `gap` cycles.
  - Then SHIFT resumes with the reloaded pattern and frame_start=1.
- DONE:
  - done=1, busy=0, valid=0 for one cycle, then IDLE.
  - A new start can be accepted in the cycle after `done`.
- Start handling:
  - `start` is ignored in SHIFT, GAP and DONE; it is not queued.
  - Input changes to pattern, repeat_n and gap during a transfer have no effect.
- Latency: start accepted at edge E0 → MSB visible in the cycle after E0. Last bit of the last frame at edge E0 + repeat_n*WIDTH + (repeat_n-1)*gap - 1. `done` follows on the next cycle.
- Counters:
  - Bit counter is ceil(log2(WIDTH)) bits.
  - Repeat counter is CNT_W bits, so the maximum is 2^CNT_W-1 frames with no wrap.
  - Gap counter is GAP_W bits.
- `data` is 0 whenever valid=0.

Test Plan:
- Single frame: rst pulse, then start with pattern=1101, repeat_n=1, gap=0 → data 1,1,0,1 with valid=1 for 4 cycles and frame_start on the first. `done` pulses in cycle 5, `busy` is high for cycles 1-4. A downstream 1101 detector asserts `out` exactly once.
- Back-to-back frames: pattern=1101, repeat_n=3, gap=0 → 12 contiguous valid bits 110111011101, frame_start in cycles 1, 5 and 9, `done` in cycle 13. The detector fires 3 times.
- Gap: pattern=1011, repeat_n=2, gap=2 → cycles 1-4 data=1011 valid=1; cycles 5-6 valid=0, data=0; cycles 7-10 data=1011 valid=1; `done` in cycle 11.
- Zero repeats and ignored start: repeat_n=0 → `done` in cycle 1, valid and busy never high. Then start with repeat_n=2, with start held high throughout → exactly 2 frames, and the pattern input changed mid-transfer is not reflected.
- Reset mid-frame: assert rst on the 3rd bit of frame 1 of 3 → on the next cycle all outputs are 0, no `done` is seen, and a following start transmits cleanly from the MSB.
- Parameter sweep: WIDTH=8, pattern=8'hA5, repeat_n=2, gap=1 → 10100101, 0, 10100101, then `done`.
